// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU opcodes,
// data-processing cmd values and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Purpose: data-processing cmd/S -> ALUControl, FlagW, NoWrite, illegal-cmd flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; consumer samples only in the EXECUTE/ALUWB states.
module mc_alu_decoder
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_SLT    = 1'b1,
    parameter bit EN_EOR    = 1'b1
) (
    input  logic [3:0]           cmd,
    input  logic                 s,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [1:0]           flag_w,
    output logic                 no_write,
    output logic                 illegal_cmd
);

    localparam bit WIDE   = (ALUCTRL_W >= 3);
    localparam bit EOR_OK = EN_EOR && WIDE;

    logic [2:0] op_sel;

    always_comb begin
        op_sel      = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        illegal_cmd = 1'b0;
        case (cmd)
            CMD_ADD: begin
                op_sel = ALU_ADD;
                flag_w = {s, s};
            end
            CMD_SUB: begin
                op_sel = ALU_SUB;
                flag_w = {s, s};
            end
            CMD_AND: begin
                op_sel = ALU_AND;
                flag_w = {s, 1'b0};
            end
            CMD_ORR: begin
                op_sel = ALU_ORR;
                flag_w = {s, 1'b0};
            end
            CMD_EOR: begin
                if (EOR_OK) begin
                    op_sel = ALU_EOR;
                    flag_w = {s, 1'b0};
                end else begin
                    illegal_cmd = 1'b1;
                end
            end
            CMD_CMP: begin
                // S=0 is reused as SLT when enabled; otherwise it behaves as a plain compare
                if (!s && EN_SLT) begin
                    if (WIDE) op_sel = ALU_SLT;
                    else      illegal_cmd = 1'b1;
                end else begin
                    op_sel   = ALU_SUB;
                    flag_w   = 2'b11;
                    no_write = 1'b1;
                end
            end
            default: illegal_cmd = 1'b1;
        endcase
    end

    assign alu_ctrl = op_sel[ALUCTRL_W-1:0];

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle ARM control FSM (FETCH..WRITEBACK) with parametrised ALU decode.
// Latency: B 3, DP 4, STR 4, LDR 5 cycles; one idle cycle after reset release.
// Backpressure: Stall holds FETCH/MEMREAD/MEMWRITE and masks IRWrite/PCWrite/MemW.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_SLT    = 1'b1,
    parameter bit EN_EOR    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 Stall,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemW,
    output logic                 RegW,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 NoWrite,
    output logic                 Branch,
    output logic                 InstrDone,
    output logic                 Illegal
);

    state_t state_q, state_d;
    logic   run_q;
    logic   illegal_q;
    logic   set_illegal;

    logic [ALUCTRL_W-1:0] dec_alu;
    logic [1:0]           dec_flag_w;
    logic                 dec_no_write;
    logic                 dec_illegal;

    mc_alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W),
        .EN_SLT    (EN_SLT),
        .EN_EOR    (EN_EOR)
    ) u_alu_dec (
        .cmd         (Funct[4:1]),
        .s           (Funct[0]),
        .alu_ctrl    (dec_alu),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write),
        .illegal_cmd (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        MemW        = 1'b0;
        RegW        = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RM;
        ALUControl  = ALUCTRL_W'(ALU_ADD);
        FlagW       = 2'b00;
        NoWrite     = 1'b0;
        Branch      = 1'b0;
        InstrDone   = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (!Stall) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                        InstrDone   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = Funct[3] ? ALUCTRL_W'(ALU_ADD) : ALUCTRL_W'(ALU_SUB);
                state_d    = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (!Stall) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = 1'b1;
                if (!Stall) state_d = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB     = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RM;
                ALUControl  = dec_alu;
                FlagW       = dec_flag_w;
                NoWrite     = dec_no_write;
                set_illegal = dec_illegal;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                RegW      = !dec_no_write && !dec_illegal;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // a register write to R15 is a jump, so the PC must load as well
        if (RegW && (Rd == 4'd15)) PCWrite = 1'b1;

        // stalled cycles repeat, so nothing that commits may fire until memory is ready
        if (Stall && (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE)) begin
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            MemW      = 1'b0;
            InstrDone = 1'b0;
        end

        // run_q clears asynchronously, so this also drops strobes the moment reset asserts
        if (!run_q) begin
            state_d     = S_FETCH;
            set_illegal = 1'b0;
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            MemW        = 1'b0;
            RegW        = 1'b0;
            FlagW       = 2'b00;
            NoWrite     = 1'b0;
            Branch      = 1'b0;
            InstrDone   = 1'b0;
        end
    end

    assign ImmSrc  = Op;
    assign RegSrc  = {Op == OP_MEM, Op == OP_BR};
    assign Illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised instruction stream for multicycle_ctrl checked against a per-instruction
// behavioural model (latency, strobe counts, decode results, sticky Illegal).
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       Stall;
    logic       PCWrite, AdrSrc, IRWrite, MemW, RegW, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;
    logic       NoWrite, Branch, InstrDone, Illegal;

    multicycle_ctrl #(
        .ALUCTRL_W (3),
        .EN_SLT    (1'b1),
        .EN_EOR    (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .Stall      (Stall),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemW       (MemW),
        .RegW       (RegW),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .NoWrite    (NoWrite),
        .Branch     (Branch),
        .InstrDone  (InstrDone),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_illegal;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ARM data-processing semantics for the default configuration
    function automatic void model_dp(input logic [5:0] f, output int alu, output int fw,
                                     output int nw, output bit ill);
        logic [3:0] cmd;
        bit         s;
        cmd = f[4:1];
        s   = f[0];
        alu = 0; fw = 0; nw = 0; ill = 1'b0;
        case (cmd)
            4'b0100: begin alu = 0; fw = s ? 3 : 0; end
            4'b0010: begin alu = 1; fw = s ? 3 : 0; end
            4'b0000: begin alu = 2; fw = s ? 2 : 0; end
            4'b1100: begin alu = 3; fw = s ? 2 : 0; end
            4'b0001: begin alu = 4; fw = s ? 2 : 0; end
            4'b1010: begin
                if (s) begin alu = 1; fw = 3; nw = 1; end
                else   alu = 5;
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_strobes", int'({PCWrite, IRWrite, MemW, RegW, Branch, InstrDone}), 0);
        chk("rst_flagw", int'(FlagW), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_illegal", int'(Illegal), 0);
        chk("rst_irwrite", int'(IRWrite), 0);
        exp_illegal = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_irwrite", int'(IRWrite), 0);
        chk("idle_pcwrite", int'(PCWrite), 0);
        @(posedge clk);
        #1;
    endtask

    // k1 stall cycles in FETCH, k2 stall cycles at the memory-access step
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input int k1, input int k2);
        int alu_e, fw_e, nw_e, lat, regw_e, memw_e, br_e;
        bit ill_e;
        int n_irw = 0, n_pcw = 0, n_memw = 0, n_regw = 0, n_br = 0, n_fw_other = 0;
        int irw_first = -1, c_done = -1;
        int ex_alu = -1, ex_fw = -1, ex_nw = -1, ex_srcb = -1;
        int f_srca = -1, f_srcb = -1, f_res = -1, adr = -1, last_res = -1, last_srcb = -1;
        int imm = -1, regsrc = -1;

        model_dp(f, alu_e, fw_e, nw_e, ill_e);
        regw_e = 0; memw_e = 0; br_e = 0;
        case (op)
            2'b00: begin lat = 4; regw_e = (!ill_e && nw_e == 0) ? 1 : 0; end
            2'b01: begin lat = (f[0] ? 5 : 4) + k2; regw_e = f[0] ? 1 : 0; memw_e = f[0] ? 0 : 1; end
            2'b10: begin lat = 3; br_e = 1; end
            default: lat = 2;
        endcase
        lat = lat + k1;
        if (op == 2'b11 || (op == 2'b00 && ill_e)) exp_illegal = 1'b1;

        Op = op; Funct = f; Rd = rd;
        for (int c = 0; c < 64 && c_done < 0; c++) begin
            @(negedge clk);
            Stall = (c < k1) || (c >= k1 + 3 && c < k1 + 3 + k2);
            #1;
            n_irw  += int'(IRWrite);
            n_pcw  += int'(PCWrite);
            n_memw += int'(MemW);
            n_regw += int'(RegW);
            n_br   += int'(Branch);
            if (IRWrite && irw_first < 0) irw_first = c;
            if (c == 0) begin imm = int'(ImmSrc); regsrc = int'(RegSrc); end
            if (c == k1) begin f_srca = int'(ALUSrcA); f_srcb = int'(ALUSrcB); f_res = int'(ResultSrc); end
            if (c == k1 + 2 && op != 2'b10) begin
                ex_alu = int'(ALUControl); ex_fw = int'(FlagW);
                ex_nw = int'(NoWrite); ex_srcb = int'(ALUSrcB);
            end else if (FlagW != 2'b00 || NoWrite) begin
                n_fw_other++;
            end
            if (c == k1 + 3) adr = int'(AdrSrc);
            if (InstrDone) begin
                c_done = c; last_res = int'(ResultSrc); last_srcb = int'(ALUSrcB);
            end
        end
        Stall = 1'b0;

        chk("latency", c_done + 1, lat);
        chk("irwrite_count", n_irw, 1);
        chk("irwrite_cycle", irw_first, k1);
        chk("pcwrite_count", n_pcw, 1 + ((regw_e == 1 && rd == 4'd15) ? 1 : 0));
        chk("memw_count", n_memw, memw_e);
        chk("regw_count", n_regw, regw_e);
        chk("branch_count", n_br, br_e);
        chk("fetch_srca", f_srca, 1);
        chk("fetch_srcb", f_srcb, 2);
        chk("fetch_result", f_res, 2);
        chk("immsrc", imm, int'(op));
        chk("regsrc", regsrc, (op == 2'b01 ? 2 : 0) + (op == 2'b10 ? 1 : 0));
        chk("flags_outside_exec", n_fw_other, 0);
        if (op == 2'b00) begin
            chk("dp_alu", ex_alu, alu_e);
            chk("dp_flagw", ex_fw, fw_e);
            chk("dp_nowrite", ex_nw, nw_e);
            chk("dp_srcb", ex_srcb, f[5] ? 1 : 0);
            chk("aluwb_result", last_res, 0);
        end else if (op == 2'b01) begin
            chk("memadr_alu", ex_alu, f[3] ? 0 : 1);
            chk("memadr_srcb", ex_srcb, 1);
            chk("mem_adrsrc", adr, 1);
            if (f[0]) chk("memwb_result", last_res, 1);
        end else if (op == 2'b10) begin
            chk("branch_result", last_res, 2);
            chk("branch_srcb", last_srcb, 1);
        end
        @(posedge clk);
        #1;
        chk("illegal_sticky", int'(Illegal), int'(exp_illegal));
    endtask

    initial begin
        logic [3:0] cmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};
        reset = 1'b0; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; Stall = 1'b0; exp_illegal = 1'b0;
        do_reset();

        run_instr(2'b00, 6'b001000, 4'd1, 0, 0);   // ADD R1,R2,R3
        run_instr(2'b00, 6'b010101, 4'd1, 0, 0);   // CMP
        run_instr(2'b00, 6'b010100, 4'd3, 0, 0);   // SLT
        run_instr(2'b01, 6'b010001, 4'd4, 0, 2);   // LDR U=0, stalled in MEMREAD
        run_instr(2'b01, 6'b011000, 4'd5, 3, 0);   // STR, stalled in FETCH
        run_instr(2'b10, 6'b000000, 4'd0, 0, 0);   // B
        run_instr(2'b00, 6'b101001, 4'd15, 0, 0);  // ADDS imm into PC
        run_instr(2'b00, 6'b000110, 4'd2, 0, 0);   // undefined cmd
        run_instr(2'b11, 6'b000000, 4'd0, 0, 0);   // undefined Op

        // reset asserted while a store sits in MEMWRITE
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            Stall = 1'b0;
        end
        #1;
        chk("memw_before_reset", int'(MemW), 1);
        do_reset();

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            int sel;
            sel = $urandom_range(0, 9);
            f   = 6'($urandom_range(0, 63));
            if (sel <= 4) begin
                op = 2'b00;
                if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
            end else if (sel <= 7) begin
                op = 2'b01;
            end else if (sel == 8) begin
                op = 2'b10;
            end else begin
                op = 2'b11;
            end
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            run_instr(op, f, rd, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
